pr_bridge: RTL and testbench
============================

# pr_bridge

Parametrised processor-bus bridge between the pipeline's MEM stage (PrAddr/PrRD/PrWD/PrBE/IOWrite) and up to six memory-mapped peripherals. It generalises single-cycle device access to a per-device ready handshake with wait states, bus timeout, unmapped-address error, and pipeline stall generation. It also aggregates device interrupt lines onto HWInt[7:2] for CP0.

## Interface
- NUM_DEV, 4, number of attached devices (1..6)
- BASE_ADDR, 32'h0000_7F00, byte address of device 0 window (window-aligned)
- WIN_LOG2, 2, log2 of words per device window
- TIMEOUT, 16, ACCESS cycles without DevRdy before error (2..255)

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- PrReq  in  1  MEM-stage access valid; held high while PrStall
- IOWrite  in  1  1 = write, 0 = read; qualified by PrReq
- PrAddr  in  30  word address [31:2]
- PrBE  in  4  byte enables
- PrWD  in  32  write data
- PrRD  out  32  read data, valid in DONE
- PrStall  out  1  freeze IF..MEM pipeline registers
- PrErr  out  1  access failed (unmapped or timeout), valid in DONE
- DevSel  out  NUM_DEV  one-hot device select
- DevWe  out  1  write strobe
- DevAddr  out  WIN_LOG2  word offset in window
- DevBE  out  4  latched byte enables
- DevWD  out  32  latched write data
- DevRD  in  NUM_DEV*32  device i read data at [32i+31:32i]
- DevRdy  in  NUM_DEV  device i completes access this cycle
- DevIrq  in  NUM_DEV  level interrupt from device i
- HWInt  out  6  interrupt lines [7:2] to CP0

## Operation
- Decode: device i hit when {PrAddr,2'b00} in [BASE_ADDR + i*2^(WIN_LOG2+2), +2^(WIN_LOG2+2)); any other address = unmapped.
- FSM states IDLE, ACCESS, DONE.
- IDLE: PrReq=1 and hit -> latch sel/offset/BE/WD/IOWrite, clear timeout counter, go ACCESS. PrReq=1 and unmapped -> latch err=1, rdata=0, go DONE. PrReq=0 -> stay.
- ACCESS: DevSel = latched one-hot, DevWe = latched write. Selected DevRdy=1 -> latch DevRD slice (reads; writes latch 0), err=0, go DONE. Else counter+1; counter reaches TIMEOUT-1 with no ready -> err=1, rdata=0, go DONE. DevRdy of unselected devices ignored.
- DONE: PrRD = latched rdata, PrErr = latched err; unconditional -> IDLE.
- PrStall (combinational) = PrReq & (state != DONE). Transaction started always finishes even if PrReq drops; result discarded if PrReq=0 in DONE.
- DevSel/DevWe zero outside ACCESS; DevAddr/DevBE/DevWD hold last latched values.
- HWInt[2+i] = registered DevIrq[i] for i < NUM_DEV; remaining bits 0.
- Reset (any time, including mid-ACCESS): state IDLE, all registers and outputs 0; device sees DevSel drop asynchronously.

## Timing
- Reset values: PrRD=0, PrStall=PrReq (state IDLE), PrErr=0, DevSel=0, DevWe=0, DevAddr=0, DevBE=0, DevWD=0, HWInt=0.
- Zero-wait device (DevRdy high when selected): request cycle T0, ACCESS T1, DONE T2; PrStall high T0–T1 (2 stall cycles).
- Each wait cycle adds one stall cycle; timeout -> DONE at T0+TIMEOUT+1.
- Unmapped: DONE at T1, 1 stall cycle.
- Back-to-back: new request accepted in IDLE cycle after DONE.

## Configuration
- PR_BRIDGE_IRQ_SYNC_EN defined: DevIrq passes a two-flop synchroniser; HWInt follows DevIrq after 2 clk edges.
- Undefined: single register stage; latency 1 clk edge.

## Test plan
- Read device 1 (NUM_DEV=4, default BASE), PrAddr={32'h7F10}[31:2], DevRdy[1] high immediately, DevRD slice 32'hCAFE_0001 -> PrStall 2 cycles, DONE PrRD=32'hCAFE_0001, PrErr=0.
- Write 32'h1234_5678, BE=4'b0011 to 32'h7F04 with 3 wait cycles -> DevSel=4'b0001, DevWe=1, DevAddr=1, DevBE=4'b0011 for 4 ACCESS cycles; PrStall 5 cycles; PrErr=0.
- Read 32'h0000_1000 -> 1 stall cycle, DONE PrRD=0, PrErr=1, DevSel never nonzero.
- Device 2 never ready, TIMEOUT=16 -> DevSel=4'b0100 for 16 cycles, DONE PrErr=1, PrRD=0, IDLE next.
- Assert rst during ACCESS wait -> DevSel=0 and PrErr=0 immediately; after release, new read to device 0 completes normally.
- DevIrq=4'b1010 -> HWInt=6'b001010 after 1 edge (macro off) / 2 edges (macro on); HWInt[7:6]=0.

Source files
------------

// File: rtl/pr_bridge_if.sv
// Processor-side and device-side signal bundle of the pr_bridge.
// The slave modport is the bridge view; the master modport is the CPU/device-model view.
interface pr_bridge_if #(
  parameter int NUM_DEV  = 4,
  parameter int WIN_LOG2 = 2
);
  logic                    PrReq;
  logic                    IOWrite;
  logic [29:0]             PrAddr;
  logic [3:0]              PrBE;
  logic [31:0]             PrWD;
  logic [31:0]             PrRD;
  logic                    PrStall;
  logic                    PrErr;
  logic [NUM_DEV-1:0]      DevSel;
  logic                    DevWe;
  logic [WIN_LOG2-1:0]     DevAddr;
  logic [3:0]              DevBE;
  logic [31:0]             DevWD;
  logic [NUM_DEV*32-1:0]   DevRD;
  logic [NUM_DEV-1:0]      DevRdy;
  logic [NUM_DEV-1:0]      DevIrq;
  logic [5:0]              HWInt;

  modport slave (
    input  PrReq, IOWrite, PrAddr, PrBE, PrWD, DevRD, DevRdy, DevIrq,
    output PrRD, PrStall, PrErr, DevSel, DevWe, DevAddr, DevBE, DevWD, HWInt
  );

  modport master (
    output PrReq, IOWrite, PrAddr, PrBE, PrWD, DevRD, DevRdy, DevIrq,
    input  PrRD, PrStall, PrErr, DevSel, DevWe, DevAddr, DevBE, DevWD, HWInt
  );
endinterface

// File: rtl/pr_bridge.sv
// MEM-stage to peripheral bridge: address decode, ready/wait-state handshake, timeout, stall, IRQ gather.
// Define PR_BRIDGE_IRQ_SYNC_EN to pass DevIrq through a two-flop synchroniser instead of one register.
module pr_bridge #(
  parameter int          NUM_DEV   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          WIN_LOG2  = 2,
  parameter int          TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  pr_bridge_if.slave  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  localparam logic [29:0] SPAN_WORDS = 30'(NUM_DEV << WIN_LOG2);
  localparam logic [7:0]  LAST_WAIT  = 8'(TIMEOUT - 1);

  state_t                r_state;
  logic [NUM_DEV-1:0]    r_dev_sel;
  logic                  r_dev_we;
  logic [WIN_LOG2-1:0]   r_dev_addr;
  logic [3:0]            r_dev_be;
  logic [31:0]           r_dev_wd;
  logic [7:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [NUM_DEV-1:0]    r_irq_sync;

  logic [29:0]           w_off;
  logic                  w_hit;
  logic [2:0]            w_idx;
  logic [NUM_DEV-1:0]    w_dec_sel;
  logic [31:0]           w_rd_data;
  logic                  w_rdy;

  // Word offset from the base; addresses below the base wrap to huge values and miss.
  assign w_off = bus.PrAddr - BASE_ADDR[31:2];
  assign w_hit = (w_off < SPAN_WORDS);
  assign w_idx = 3'(w_off >> WIN_LOG2);

  always_comb begin
    w_dec_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_dec_sel[i] = (w_idx == 3'(i));
    end
  end

  // Only the selected device's data and ready are observed.
  always_comb begin
    w_rd_data = '0;
    w_rdy     = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (r_dev_sel[i]) begin
        w_rd_data = w_rd_data | bus.DevRD[32*i +: 32];
        w_rdy     = w_rdy | bus.DevRdy[i];
      end
    end
  end

  // NOTE: state is assigned with <= so every branch sees pre-edge values; DevSel/DevWe are
  // registers so that reset removes them asynchronously from the devices.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_dev_sel  <= '0;
      r_dev_we   <= 1'b0;
      r_dev_addr <= '0;
      r_dev_be   <= '0;
      r_dev_wd   <= '0;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.PrReq) begin
            if (w_hit) begin
              r_dev_sel  <= w_dec_sel;
              r_dev_we   <= bus.IOWrite;
              r_dev_addr <= w_off[WIN_LOG2-1:0];
              r_dev_be   <= bus.PrBE;
              r_dev_wd   <= bus.PrWD;
              r_cnt      <= '0;
              r_state    <= ST_ACCESS;
            end else begin
              r_err   <= 1'b1;
              r_rdata <= '0;
              r_state <= ST_DONE;
            end
          end
        end
        ST_ACCESS: begin
          if (w_rdy) begin
            r_rdata   <= r_dev_we ? 32'h0 : w_rd_data;
            r_err     <= 1'b0;
            r_dev_sel <= '0;
            r_dev_we  <= 1'b0;
            r_state   <= ST_DONE;
          end else if (r_cnt == LAST_WAIT) begin
            r_rdata   <= '0;
            r_err     <= 1'b1;
            r_dev_sel <= '0;
            r_dev_we  <= 1'b0;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef PR_BRIDGE_IRQ_SYNC_EN
  logic [NUM_DEV-1:0] r_irq_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_meta <= '0;
      r_irq_sync <= '0;
    end else begin
      r_irq_meta <= bus.DevIrq;
      r_irq_sync <= r_irq_meta;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_sync <= '0;
    end else begin
      r_irq_sync <= bus.DevIrq;
    end
  end
`endif

  assign bus.PrStall = bus.PrReq & (r_state != ST_DONE);
  assign bus.PrRD    = r_rdata;
  assign bus.PrErr   = r_err;
  assign bus.DevSel  = r_dev_sel;
  assign bus.DevWe   = r_dev_we;
  assign bus.DevAddr = r_dev_addr;
  assign bus.DevBE   = r_dev_be;
  assign bus.DevWD   = r_dev_wd;
  assign bus.HWInt   = 6'(r_irq_sync);

endmodule

// File: tb/tb_pr_bridge.sv
// Randomized self-checking bench for pr_bridge against a transaction-level model
// (decode arithmetic, wait/timeout cycle counts, IRQ delay line).
module tb_pr_bridge;
  localparam int          NUM_DEV   = 4;
  localparam logic [31:0] BASE      = 32'h0000_7F00;
  localparam int          WIN_LOG2  = 2;
  localparam int          TIMEOUT   = 16;
  localparam int          WIN_BYTES = 4 << WIN_LOG2;
`ifdef PR_BRIDGE_IRQ_SYNC_EN
  localparam int          IRQ_LAT   = 2;
`else
  localparam int          IRQ_LAT   = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pr_bridge_if #(.NUM_DEV(NUM_DEV), .WIN_LOG2(WIN_LOG2)) bus ();

  pr_bridge #(
    .NUM_DEV  (NUM_DEV),
    .BASE_ADDR(BASE),
    .WIN_LOG2 (WIN_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NUM_DEV-1:0] irq_d1   = '0;
  logic [NUM_DEV-1:0] irq_d2   = '0;
  logic [37:0]        last_bus = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next falling edge, record what the IRQ stages captured, then randomize device inputs.
  task automatic next_cycle();
    @(negedge clk);
    if (rst) begin
      irq_d1 = '0;
      irq_d2 = '0;
    end else begin
      irq_d2 = irq_d1;
      irq_d1 = bus.DevIrq;
    end
    bus.DevIrq = NUM_DEV'($urandom);
    bus.DevRdy = NUM_DEV'($urandom);
    for (int i = 0; i < NUM_DEV; i++) bus.DevRD[32*i +: 32] = $urandom;
  endtask

  task automatic check_irq();
    logic [5:0] e;
    e = 6'((IRQ_LAT == 2) ? irq_d2 : irq_d1);
    check("hwint", 64'(bus.HWInt), 64'(e));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      next_cycle();
      bus.PrReq   = 1'b0;
      bus.PrAddr  = 30'($urandom);
      bus.IOWrite = 1'($urandom);
      #1;
      check_irq();
      check("idle_stall", 64'(bus.PrStall), 64'(0));
      check("idle_sel", 64'(bus.DevSel), 64'(0));
      check("idle_we", 64'(bus.DevWe), 64'(0));
      check("hold_bus", 64'({bus.DevAddr, bus.DevBE, bus.DevWD}), 64'(last_bus));
    end
  endtask

  // One processor access; wait_n = device wait cycles before ready, drop_at = cycle PrReq falls
  // (-1 never), rst_at = cycle reset is asserted (-1 never).
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] rd_val,
                         input int wait_n, input int drop_at, input int rst_at);
    logic [31:0]        off;
    bit                 hit;
    bit                 err;
    int                 idx;
    int                 acc;
    int                 s;
    logic [31:0]        exp_rd;
    logic [NUM_DEV-1:0] exp_sel;
    logic [37:0]        exp_bus;
    logic               req;

    off     = addr - BASE;
    hit     = (addr >= BASE) && (off < 32'(NUM_DEV * WIN_BYTES));
    idx     = int'(off / 32'(WIN_BYTES));
    acc     = (wait_n + 1 < TIMEOUT) ? wait_n + 1 : TIMEOUT;
    s       = hit ? 1 + acc : 1;
    err     = !hit || (wait_n >= TIMEOUT);
    exp_rd  = (err || we) ? 32'h0 : rd_val;
    exp_bus = {2'((off % 32'(WIN_BYTES)) / 32'd4), be, wd};
    req     = 1'b1;

    for (int k = 0; k <= s; k++) begin
      next_cycle();
      if (k == 0) begin
        bus.IOWrite = we;
        bus.PrAddr  = addr[31:2];
        bus.PrBE    = be;
        bus.PrWD    = wd;
      end
      if (drop_at > 0 && k >= drop_at) req = 1'b0;
      bus.PrReq = req;
      if (hit) begin
        bus.DevRD[32*idx +: 32] = rd_val;
        if (k >= 1) bus.DevRdy[idx] = (k - 1 >= wait_n);
      end
      #1;
      check_irq();
      check("stall", 64'(bus.PrStall), 64'(req && (k < s)));
      exp_sel = (hit && k >= 1 && k < s) ? (NUM_DEV'(1) << idx) : '0;
      check("dev_sel", 64'(bus.DevSel), 64'(exp_sel));
      check("dev_we", 64'(bus.DevWe), 64'((exp_sel != '0) && we));
      if (exp_sel != '0)
        check("dev_bus", 64'({bus.DevAddr, bus.DevBE, bus.DevWD}), 64'(exp_bus));
      if (k == s) begin
        check("pr_err", 64'(bus.PrErr), 64'(err));
        check("pr_rd", 64'(bus.PrRD), 64'(exp_rd));
      end
      if (k == rst_at) begin
        #1 rst = 1'b1;
        #1;
        check("rst_sel", 64'(bus.DevSel), 64'(0));
        check("rst_we", 64'(bus.DevWe), 64'(0));
        check("rst_err", 64'(bus.PrErr), 64'(0));
        check("rst_rd", 64'(bus.PrRD), 64'(0));
        check("rst_stall", 64'(bus.PrStall), 64'(req));
        check("rst_hwint", 64'(bus.HWInt), 64'(0));
        check("rst_bus", 64'({bus.DevAddr, bus.DevBE, bus.DevWD}), 64'(0));
        last_bus = '0;
        next_cycle();
        bus.PrReq = 1'b0;
        rst       = 1'b0;
        #1;
        check_irq();
        check("post_rst_stall", 64'(bus.PrStall), 64'(0));
        return;
      end
    end
    if (hit) last_bus = exp_bus;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.PrReq   = 1'b0;
    bus.IOWrite = 1'b0;
    bus.PrAddr  = '0;
    bus.PrBE    = '0;
    bus.PrWD    = '0;
    bus.DevRD   = '0;
    bus.DevRdy  = '0;
    bus.DevIrq  = '0;
    rst         = 1'b1;

    repeat (2) @(negedge clk);
    #1;
    check("reset_prrd", 64'(bus.PrRD), 64'(0));
    check("reset_stall", 64'(bus.PrStall), 64'(0));
    check("reset_err", 64'(bus.PrErr), 64'(0));
    check("reset_sel", 64'(bus.DevSel), 64'(0));
    check("reset_we", 64'(bus.DevWe), 64'(0));
    check("reset_bus", 64'({bus.DevAddr, bus.DevBE, bus.DevWD}), 64'(0));
    check("reset_hwint", 64'(bus.HWInt), 64'(0));
    bus.PrReq = 1'b1;
    #1;
    check("reset_stall_req", 64'(bus.PrStall), 64'(1));
    bus.PrReq = 1'b0;

    next_cycle();
    rst = 1'b0;
    idle(2);

    run_txn(32'h7F10, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, 0, -1, -1);
    run_txn(32'h7F04, 1'b1, 4'b0011, 32'h1234_5678, $urandom, 3, -1, -1);
    run_txn(32'h0000_1000, 1'b0, 4'hF, 32'h0, $urandom, 0, -1, -1);
    run_txn(32'h7F20, 1'b0, 4'hF, 32'h0, $urandom, 1000, -1, -1);
    run_txn(32'h7F2C, 1'b0, 4'hF, 32'h0, $urandom, 1000, -1, 6);
    run_txn(32'h7F00, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1, -1, -1);
    idle(1);
    run_txn(32'h7EFC, 1'b0, 4'hF, 32'h0, $urandom, 0, -1, -1);
    run_txn(32'h7F40, 1'b1, 4'hF, $urandom, $urandom, 0, -1, -1);
    run_txn(32'h7F3C, 1'b0, 4'hF, 32'h0, 32'h5A5A_A5A5, TIMEOUT - 1, -1, -1);
    run_txn(32'h7F30, 1'b1, 4'b1100, 32'hDEAD_BEEF, $urandom, TIMEOUT, -1, -1);
    run_txn(32'h7F18, 1'b0, 4'hF, 32'h0, 32'h7777_0000, 2, 1, -1);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      int          w;
      int          d;
      if ($urandom_range(0, 9) < 8)
        a = BASE + 32'($urandom_range(0, NUM_DEV * WIN_BYTES / 4 - 1) * 4);
      else
        a = $urandom & ~32'h3;
      if ($urandom_range(0, 9) == 0) w = int'($urandom_range(14, 20));
      else                           w = int'($urandom_range(0, 4));
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_txn(a, 1'($urandom), 4'($urandom), $urandom, $urandom, w, d, -1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
